// File: rtl/ctl_game.sv
// ctl_game: Duck Hunt round/duck sequencer (spawn, shots, timeouts, rounds).
// Define CTL_GAME_PERFECT_BONUS_EN for the perfect_round pulse and +2 advance.
module ctl_game #(
   parameter int unsigned DUCKS_PER_ROUND = 10,
   parameter int unsigned HITS_TO_PASS    = 6,
   parameter int unsigned SHOTS_PER_DUCK  = 3,
   parameter int unsigned FLIGHT_FRAMES   = 300,
   parameter int unsigned PAUSE_FRAMES    = 120,
   parameter int unsigned MAX_ROUND       = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       new_frame,
   input  logic       start,
   input  logic       pause,
   input  logic       hit,
   input  logic       shot_fired,
   output logic       duck_spawn,
   output logic       duck_fly_away,
   output logic [2:0] shots_left,
   output logic [3:0] duck_idx,
   output logic [3:0] round_hits,
   output logic [6:0] round_num,
   output logic       game_over,
`ifdef CTL_GAME_PERFECT_BONUS_EN
   output logic       perfect_round,
`endif
   output logic       reset_score
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SPAWN     = 3'd1;
   localparam logic [2:0] S_FLIGHT    = 3'd2;
   localparam logic [2:0] S_ESCAPE    = 3'd3;
   localparam logic [2:0] S_DUCK_END  = 3'd4;
   localparam logic [2:0] S_ROUND_END = 3'd5;
   localparam logic [2:0] S_GAME_OVER = 3'd6;

   localparam logic [2:0] SHOTS_INIT  = 3'(SHOTS_PER_DUCK);
   localparam logic [9:0] FLIGHT_INIT = 10'(FLIGHT_FRAMES);
   localparam logic [9:0] PAUSE_INIT  = 10'(PAUSE_FRAMES);
   localparam logic [3:0] LAST_DUCK   = 4'(DUCKS_PER_ROUND - 1);
   localparam logic [3:0] HITS_PASS   = 4'(HITS_TO_PASS);
   localparam logic [7:0] ROUND_MAX   = 8'(MAX_ROUND);
`ifdef CTL_GAME_PERFECT_BONUS_EN
   localparam logic [3:0] HITS_ALL    = 4'(DUCKS_PER_ROUND);
`endif

   logic [2:0] state;
   logic [2:0] state_nx;
   logic [9:0] timer;
   logic [9:0] timer_nx;
   logic [2:0] shots_nx;
   logic [3:0] idx_nx;
   logic [3:0] hits_nx;
   logic [6:0] round_nx;
   logic       fly_nx;
   logic       over_nx;
   logic       spawn_nx;
   logic       rscore_nx;
`ifdef CTL_GAME_PERFECT_BONUS_EN
   logic       perfect_nx;
   logic       all_hit;
`endif

   logic [2:0] shots_dec;
   logic [3:0] hits_inc;
   logic [7:0] round_step;
   logic [7:0] round_sum;
   logic [6:0] round_adv;
   logic       expire;

   assign shots_dec = (shots_left == 3'd0) ? 3'd0
                    : shots_left - 3'd1;
   assign hits_inc  = (round_hits == 4'hf) ? 4'hf
                    : round_hits + 4'd1;
   assign expire    = new_frame && (timer <= 10'd1);

`ifdef CTL_GAME_PERFECT_BONUS_EN
   assign all_hit    = (round_hits == HITS_ALL);
   assign round_step = all_hit ? 8'd2 : 8'd1;
`else
   assign round_step = 8'd1;
`endif

   assign round_sum = {1'b0, round_num} + round_step;
   assign round_adv = (round_sum > ROUND_MAX) ? ROUND_MAX[6:0]
                    : round_sum[6:0];

   // Next-state decode; a high pause holds every register and drops pulses.
   always_comb begin
      state_nx  = state;
      timer_nx  = timer;
      shots_nx  = shots_left;
      idx_nx    = duck_idx;
      hits_nx   = round_hits;
      round_nx  = round_num;
      fly_nx    = duck_fly_away;
      over_nx   = game_over;
      spawn_nx  = 1'b0;
      rscore_nx = 1'b0;
`ifdef CTL_GAME_PERFECT_BONUS_EN
      perfect_nx = 1'b0;
`endif
      if (!pause) begin
         if (new_frame && timer != 10'd0)
            timer_nx = timer - 10'd1;
         unique case (state)
            S_IDLE, S_GAME_OVER: begin
               if (start) begin
                  rscore_nx = 1'b1;
                  round_nx  = 7'd1;
                  hits_nx   = 4'd0;
                  idx_nx    = 4'd0;
                  shots_nx  = 3'd0;
                  fly_nx    = 1'b0;
                  over_nx   = 1'b0;
                  timer_nx  = 10'd0;
                  state_nx  = S_SPAWN;
               end
            end
            S_SPAWN: begin
               spawn_nx = 1'b1;
               shots_nx = SHOTS_INIT;
               timer_nx = FLIGHT_INIT;
               state_nx = S_FLIGHT;
            end
            S_FLIGHT: begin
               // a hit outranks a simultaneous shot or timeout
               if (hit) begin
                  hits_nx  = hits_inc;
                  shots_nx = shots_dec;
                  timer_nx = PAUSE_INIT;
                  state_nx = S_DUCK_END;
               end else begin
                  if (shot_fired)
                     shots_nx = shots_dec;
                  if ((shot_fired && shots_dec == 3'd0) || expire) begin
                     fly_nx   = 1'b1;
                     state_nx = S_ESCAPE;
                  end
               end
            end
            S_ESCAPE: begin
               timer_nx = PAUSE_INIT;
               state_nx = S_DUCK_END;
            end
            S_DUCK_END: begin
               if (expire) begin
                  fly_nx = 1'b0;
                  if (duck_idx == LAST_DUCK) begin
                     timer_nx = PAUSE_INIT;
                     state_nx = S_ROUND_END;
                  end else begin
                     idx_nx   = duck_idx + 4'd1;
                     state_nx = S_SPAWN;
                  end
               end
            end
            S_ROUND_END: begin
               if (expire) begin
                  if (round_hits >= HITS_PASS) begin
                     round_nx = round_adv;
                     hits_nx  = 4'd0;
                     idx_nx   = 4'd0;
                     state_nx = S_SPAWN;
`ifdef CTL_GAME_PERFECT_BONUS_EN
                     perfect_nx = all_hit;
`endif
                  end else begin
                     over_nx  = 1'b1;
                     state_nx = S_GAME_OVER;
                  end
               end
            end
            default: begin
               state_nx = S_IDLE;
            end
         endcase
      end
   end

   // State, timer and registered outputs; reset returns to the idle view.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         timer         <= 10'd0;
         shots_left    <= 3'd0;
         duck_idx      <= 4'd0;
         round_hits    <= 4'd0;
         round_num     <= 7'd1;
         duck_fly_away <= 1'b0;
         game_over     <= 1'b0;
         duck_spawn    <= 1'b0;
         reset_score   <= 1'b0;
`ifdef CTL_GAME_PERFECT_BONUS_EN
         perfect_round <= 1'b0;
`endif
      end else begin
         state         <= state_nx;
         timer         <= timer_nx;
         shots_left    <= shots_nx;
         duck_idx      <= idx_nx;
         round_hits    <= hits_nx;
         round_num     <= round_nx;
         duck_fly_away <= fly_nx;
         game_over     <= over_nx;
         duck_spawn    <= spawn_nx;
         reset_score   <= rscore_nx;
`ifdef CTL_GAME_PERFECT_BONUS_EN
         perfect_round <= perfect_nx;
`endif
      end
   end

endmodule

// File: tb/tb_ctl_game.sv
// tb_ctl_game: random stimulus, procedural game model, scoreboard queue.
// The model predicts every output change; the monitor checks each DUT change.
module tb_ctl_game;

   localparam int N  = 2;
   localparam int H  = 1;
   localparam int S  = 3;
   localparam int F  = 4;
   localparam int P  = 2;
   localparam int MX = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic new_frame = 1'b0;
   logic start = 1'b0;
   logic pause = 1'b0;
   logic hit = 1'b0;
   logic shot_fired = 1'b0;
   logic duck_spawn, duck_fly_away, game_over, reset_score;
   logic perfect_round;
   logic [2:0] shots_left;
   logic [3:0] duck_idx, round_hits;
   logic [6:0] round_num;

   ctl_game #(
      .DUCKS_PER_ROUND(N), .HITS_TO_PASS(H), .SHOTS_PER_DUCK(S),
      .FLIGHT_FRAMES(F), .PAUSE_FRAMES(P), .MAX_ROUND(MX)
   ) dut (
      .clk(clk), .rst(rst), .new_frame(new_frame), .start(start),
      .pause(pause), .hit(hit), .shot_fired(shot_fired),
      .duck_spawn(duck_spawn), .duck_fly_away(duck_fly_away),
      .shots_left(shots_left), .duck_idx(duck_idx),
      .round_hits(round_hits), .round_num(round_num),
      .game_over(game_over),
`ifdef CTL_GAME_PERFECT_BONUS_EN
      .perfect_round(perfect_round),
`endif
      .reset_score(reset_score)
   );
`ifndef CTL_GAME_PERFECT_BONUS_EN
   assign perfect_round = 1'b0;
`endif

   typedef logic [22:0] snap_t;
   typedef struct {
      int    c;
      snap_t v;
   } exp_t;

   localparam snap_t RST_SNAP = {5'b0, 3'd0, 4'd0, 4'd0, 7'd1};

   function automatic snap_t pack(
      input logic rs, sp, fly, ov, pf,
      input logic [2:0] sh,
      input logic [3:0] ix, hs,
      input logic [6:0] rn);
      return {rs, sp, fly, ov, pf, sh, ix, hs, rn};
   endfunction

   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   exp_t  q[$];
   snap_t e_last = RST_SNAP;
   snap_t d_last = RST_SNAP;
   snap_t cur;
   snap_t got;
   exp_t  ex;

   logic e_rs = 0, e_sp = 0, e_fly = 0, e_ov = 0, e_pf = 0;
   logic [2:0] e_sh = 0;
   logic [3:0] e_idx = 0, e_hits = 0;
   logic [6:0] e_rnd = 7'd1;
   logic i_start, i_pause, i_hit, i_shot, i_frame;
   bit   ok;

   // 100 MHz-ish bench clock
   always #5 clk = ~clk;

   // Cycle stamp shared by model publisher and monitor
   always @(posedge clk) cyc <= cyc + 1;

   task automatic mclk();
      @(posedge clk);
      i_start = start;
      i_pause = pause;
      i_hit   = hit;
      i_shot  = shot_fired;
      i_frame = new_frame;
      e_rs = 1'b0;
      e_sp = 1'b0;
      e_pf = 1'b0;
   endtask

   task automatic act();
      do mclk(); while (i_pause);
   endtask

   task automatic wait_frames(input int n);
      int c = 0;
      while (c < n) begin
         act();
         if (i_frame) c++;
      end
   endtask

   task automatic play_duck(input int d);
      int frames = 0;
      bit done = 0;
      bit esc = 0;
      act();
      e_sp = 1'b1;
      e_sh = 3'(S);
      while (!done) begin
         act();
         if (i_hit) begin
            if (e_hits != 4'd15) e_hits = e_hits + 4'd1;
            if (e_sh != 3'd0) e_sh = e_sh - 3'd1;
            done = 1;
         end else begin
            if (i_shot && e_sh != 3'd0) e_sh = e_sh - 3'd1;
            if (i_frame) frames++;
            if ((i_shot && e_sh == 3'd0) || frames >= F) begin
               e_fly = 1'b1;
               done = 1;
               esc = 1;
            end
         end
      end
      if (esc) act();
      wait_frames(P);
      e_fly = 1'b0;
      if (d != N - 1) e_idx = 4'(d + 1);
   endtask

   task automatic play_round(output bit passed);
      int step;
      for (int d = 0; d < N; d++) play_duck(d);
      wait_frames(P);
      passed = (int'(e_hits) >= H);
      if (passed) begin
         step = 1;
`ifdef CTL_GAME_PERFECT_BONUS_EN
         if (int'(e_hits) == N) begin
            step = 2;
            e_pf = 1'b1;
         end
`endif
         if (int'(e_rnd) + step > MX) e_rnd = 7'(MX);
         else e_rnd = 7'(int'(e_rnd) + step);
         e_hits = 4'd0;
         e_idx = 4'd0;
      end else begin
         e_ov = 1'b1;
      end
   endtask

   // Reference model: a game narrated duck by duck, round by round
   initial begin : model
      wait (rst == 1'b0);
      forever begin
         do act(); while (!i_start);
         e_rs = 1'b1;
         e_rnd = 7'd1;
         e_hits = 4'd0;
         e_idx = 4'd0;
         e_sh = 3'd0;
         e_fly = 1'b0;
         e_ov = 1'b0;
         do play_round(ok); while (ok);
      end
   end

   // Publish each predicted output change with its cycle stamp
   always @(posedge clk) begin
      #1;
      cur = pack(e_rs, e_sp, e_fly, e_ov, e_pf, e_sh, e_idx, e_hits, e_rnd);
      if (cur != e_last) begin
         q.push_back('{cyc, cur});
         e_last = cur;
      end
   end

   // Monitor: every DUT output change must match the next prediction
   always @(negedge clk) begin
      if (!rst) begin
         got = pack(reset_score, duck_spawn, duck_fly_away, game_over,
                    perfect_round, shots_left, duck_idx, round_hits,
                    round_num);
         if (got !== d_last) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL out_change cyc=%0d got=%h required=no change",
                        cyc, got);
            end else begin
               ex = q.pop_front();
               if (ex.c != cyc || ex.v !== got) begin
                  errors++;
                  $display("FAIL out_change cyc=%0d got=%h required=%h@%0d",
                           cyc, got, ex.v, ex.c);
               end
            end
            d_last = got;
         end
      end
   end

   task automatic drive(input bit s, p, h, sh, f);
      @(posedge clk);
      #1;
      start = s;
      pause = p;
      hit = h;
      shot_fired = sh;
      new_frame = f;
   endtask

   task automatic rand_phase(input int n, input int pf, input int ph,
                             input int ps, input int pst, input int pp);
      int hold = 0;
      for (int i = 0; i < n; i++) begin
         bit p;
         if (hold == 0 && int'($urandom_range(99)) < pp)
            hold = int'($urandom_range(30, 1));
         p = (hold != 0);
         if (hold != 0) hold--;
         drive(int'($urandom_range(99)) < pst, p,
               int'($urandom_range(99)) < ph,
               int'($urandom_range(99)) < ps,
               int'($urandom_range(99)) < pf);
      end
   endtask

   initial begin : stim
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      got = pack(reset_score, duck_spawn, duck_fly_away, game_over,
                 perfect_round, shots_left, duck_idx, round_hits,
                 round_num);
      if (got !== RST_SNAP) begin
         errors++;
         $display("FAIL reset_state got=%h required=%h", got, RST_SNAP);
      end

      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      repeat (3) begin
         drive(0, 0, 0, 1, 0);
         drive(0, 0, 0, 0, 0);
      end
      repeat (3) begin
         drive(0, 0, 0, 0, 1);
         drive(0, 0, 0, 0, 0);
      end
      repeat (8) begin
         drive(0, 0, 0, 0, 1);
         drive(0, 0, 0, 0, 0);
      end
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0);
      repeat (3) drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      repeat (10) begin
         drive(0, 1, 0, 0, 1);
         drive(0, 1, 1, 1, 0);
      end
      drive(1, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      repeat (8) drive(0, 0, 0, 0, 1);

      rand_phase(3000, 20, 0, 6, 5, 0);
      rand_phase(5000, 10, 10, 4, 2, 0);
      rand_phase(6000, 15, 5, 6, 3, 3);

      repeat (20) drive(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_changes got=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctl_game.md
Name: ctl_game

Overview:
Round/duck sequencer for Duck Hunt. Sits in the ctrl section beside ctl_duck, ctl_score and ctl_ammo. Consumes shot results from ctl_trigger and frame ticks from vga_timing. Schedules duck launches, per-duck shot budget, flight timeout, intermission, round pass/fail and game over; drives spawn/fly-away commands and overlay/score control.

Parameters:
DUCKS_PER_ROUND, 10, ducks launched per round (1..15)
HITS_TO_PASS, 6, hits required in a round to advance (<= DUCKS_PER_ROUND)
SHOTS_PER_DUCK, 3, shots allowed before the duck escapes (1..7)
FLIGHT_FRAMES, 300, frames a duck may fly before escaping (1..1023)
PAUSE_FRAMES, 120, intermission frames after a duck ends and after a round ends (1..1023)
MAX_ROUND, 99, round counter saturation value (1..127)

Ports:
clk  in  1  65 MHz system clock
rst  in  1  asynchronous active-high reset
new_frame  in  1  one-cycle pulse per VGA frame
start  in  1  one-cycle pulse, start/restart game
pause  in  1  level; freezes sequencing while high
hit  in  1  one-cycle pulse, duck hit
shot_fired  in  1  one-cycle pulse, any shot
duck_spawn  out  1  one-cycle pulse, launch new duck
duck_fly_away  out  1  level, duck must leave screen
shots_left  out  3  remaining shots for current duck
duck_idx  out  4  index of current duck in round (0-based)
round_hits  out  4  hits counted this round
round_num  out  7  current round, starts at 1
game_over  out  1  level, overlay "looser" flag
reset_score  out  1  one-cycle pulse to ctl_score/ctl_ammo on game start

Behaviour:
- Reset (async): state IDLE; all pulses 0; duck_fly_away=0; shots_left=0; duck_idx=0; round_hits=0; round_num=1; game_over=0; timers=0.
- All outputs registered; response to an input pulse appears one cycle later.
- Frame timer decrements only on new_frame with pause=0. While pause=1: no state change, hit/shot_fired/start ignored, timer frozen.
- States:
  IDLE: on start -> reset_score pulse, round_num=1, round_hits=0, duck_idx=0 -> SPAWN.
  SPAWN: one cycle; duck_spawn pulse; shots_left=SHOTS_PER_DUCK; timer=FLIGHT_FRAMES -> FLIGHT.
  FLIGHT: hit -> round_hits+1, shots_left-1 -> DUCK_END. Else shot_fired -> shots_left-1; if result 0 -> ESCAPE. Else timer reaches 0 -> ESCAPE.
  ESCAPE: duck_fly_away=1; timer=PAUSE_FRAMES -> DUCK_END wait.
  DUCK_END: wait for timer expiry (timer loaded with PAUSE_FRAMES on entry). On expiry, duck_fly_away=0. If duck_idx=DUCKS_PER_ROUND-1 -> ROUND_END, else duck_idx+1 -> SPAWN.
  ROUND_END: timer=PAUSE_FRAMES. On expiry: round_hits>=HITS_TO_PASS -> round_num+1 (saturate MAX_ROUND), round_hits=0, duck_idx=0 -> SPAWN. Otherwise -> GAME_OVER.
  GAME_OVER: game_over=1; on start -> same as IDLE start, game_over=0.
- Simultaneous events: hit and shot_fired in the same cycle count as one shot (shot decremented once), hit wins. Hit and timer expiry in the same cycle: hit wins. Hit on the last shot: hit wins, no escape.
- shots_left never underflows below 0. round_hits saturates at 15. shot_fired outside FLIGHT is ignored.
- start in SPAWN/FLIGHT/ESCAPE/DUCK_END/ROUND_END is ignored.

Optional Feature:
CTL_GAME_PERFECT_BONUS_EN: when defined, adds output perfect_round (1-bit, one-cycle pulse). It is asserted on ROUND_END expiry when round_hits==DUCKS_PER_ROUND. That round also advances round_num by 2 (still saturating). When undefined, the port is absent and the advance is always +1.

Test Plan:
- Bench params DUCKS_PER_ROUND=2, HITS_TO_PASS=1, SHOTS_PER_DUCK=3, FLIGHT_FRAMES=4, PAUSE_FRAMES=2, MAX_ROUND=3.
- Reset then start -> reset_score pulse next cycle, duck_spawn pulse following cycle, shots_left=3, round_num=1.
- 3 shot_fired, no hit -> shots_left 2,1,0; duck_fly_away=1 the cycle after the 3rd shot; clears after 2 new_frames; duck_idx=1; second duck_spawn pulse.
- No shots, 4 new_frames -> duck_fly_away=1 (timeout escape); hit plus shot_fired in the same cycle -> round_hits=1, shots_left=2.
- Round with 0 hits -> after ROUND_END 2 frames, game_over=1; start -> game_over=0, round_num=1, reset_score pulse.
- Pass rounds repeatedly -> round_num 1,2,3,3 (saturated). pause=1 held for 10 frames mid-FLIGHT -> timer, shots and state unchanged; hit ignored.
